// File: rtl/usb_tx_pkt_ctrl.sv
// usb_tx_pkt_ctrl
// ---------------------------------------------------------------------------
// Packet sequencer for a USB-style byte transmitter. It emits SYNC_BYTE, then
// the PID byte {~pid, pid}, then payload bytes from a small FIFO for data
// packets, or 8'h00 filler for all other packets. The external bit timer
// paces the sequence with byte_sent, and ends the packet with data_sent.
//
// Optional feature:
//   USB_TX_UNDERRUN_EN  when defined, sets a sticky underrun flag whenever a
//                       payload byte is needed and the FIFO is empty. When it
//                       is undefined, underrun is tied to 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, wr_data  payload byte push (see acceptance rule below)
//   fifo_full       FIFO holds FIFO_DEPTH bytes
//   start_pkt, pid  one-cycle packet request plus packet identifier
//   byte_sent       timer pulse: current byte fully shifted out
//   data_sent       timer pulse: packet complete (wins over byte_sent)
//   transmitting    packet in progress (timer count enable)
//   transmit_empty  packet carries no payload (timer short length)
//   tx_byte         byte presented to the shift register
//   busy            FSM not idle
//   pkt_done        one-cycle pulse in the first idle cycle after a packet
//   underrun        sticky payload-underrun flag
//   dbg_state       current FSM state encoding (IDLE=0 .. HOLD=4)
//
// Write acceptance: a byte is accepted on a clock edge where wr_en is high
// and either the FIFO is not full or a pop happens on the same edge. A write
// that is not accepted is dropped and leaves the FIFO untouched. There is no
// back-pressure signal other than fifo_full.
// ---------------------------------------------------------------------------
module usb_tx_pkt_ctrl #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    input  logic       start_pkt,
    input  logic [3:0] pid,
    input  logic       byte_sent,
    input  logic       data_sent,
    output logic       transmitting,
    output logic       transmit_empty,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       pkt_done,
    output logic       underrun,
    output logic [2:0] dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        PID  = 3'd2,
        DATA = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t      state_q;
    logic [3:0]  pid_q;
    logic [7:0]  tx_byte_q;
    logic        transmitting_q;
    logic        transmit_empty_q;
    logic        pkt_done_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic       fifo_empty;
    logic       data_pkt;
    logic       payload_slot;
    logic       pop;
    logic       push;
    logic [7:0] fifo_head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_head  = mem[rd_ptr_q];

    // transmit_empty is latched at packet start, so its inverse is the
    // data-packet qualifier for the whole packet.
    assign data_pkt = ~transmit_empty_q;

    // A payload byte is required when the current byte finishes in PID (data
    // packet) or DATA, unless the packet ends on the same edge.
    assign payload_slot = byte_sent && !data_sent &&
                          ((state_q == DATA) || ((state_q == PID) && data_pkt));
    assign pop  = payload_slot && !fifo_empty;
    assign push = wr_en && (!fifo_full || pop);

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            pid_q            <= 4'h0;
            tx_byte_q        <= 8'h00;
            transmitting_q   <= 1'b0;
            transmit_empty_q <= 1'b1;
            pkt_done_q       <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            if (state_q == IDLE) begin
                // Timer pulses in IDLE are ignored; tx_byte keeps its value.
                if (start_pkt) begin
                    state_q          <= SYNC;
                    pid_q            <= pid;
                    tx_byte_q        <= SYNC_BYTE;
                    transmitting_q   <= 1'b1;
                    transmit_empty_q <= (pid[1:0] != 2'b11);
                end
            end else if (data_sent) begin
                state_q        <= IDLE;
                transmitting_q <= 1'b0;
                pkt_done_q     <= 1'b1;
            end else if (byte_sent) begin
                case (state_q)
                    SYNC: begin
                        state_q   <= PID;
                        tx_byte_q <= {~pid_q, pid_q};
                    end
                    PID: begin
                        if (data_pkt) begin
                            state_q   <= DATA;
                            tx_byte_q <= fifo_empty ? 8'h00 : fifo_head;
                        end else begin
                            state_q   <= HOLD;
                            tx_byte_q <= 8'h00;
                        end
                    end
                    DATA: begin
                        // Starved FIFO: send filler and leave the pointer alone.
                        tx_byte_q <= fifo_empty ? 8'h00 : fifo_head;
                    end
                    HOLD: begin
                        tx_byte_q <= 8'h00;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign transmitting   = transmitting_q;
    assign transmit_empty = transmit_empty_q;
    assign tx_byte        = tx_byte_q;
    assign busy           = (state_q != IDLE);
    assign pkt_done       = pkt_done_q;
    assign dbg_state      = state_q;

    // ------------------------------------------------------------ underrun
`ifdef USB_TX_UNDERRUN_EN
    logic underrun_q;
    logic starve;

    assign starve = payload_slot && fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else if ((state_q == IDLE) && start_pkt) begin
            underrun_q <= 1'b0;
        end else if (starve) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Self-checking bench for usb_tx_pkt_ctrl. Expected tx_byte values are queued
// as each timer/start stimulus is applied and compared on the following
// falling edge; control flags are compared inline in each scenario task.
module tb_usb_tx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_full;
    logic       start_pkt = 1'b0;
    logic [3:0] pid = 4'h0;
    logic       byte_sent = 1'b0;
    logic       data_sent = 1'b0;
    logic       transmitting;
    logic       transmit_empty;
    logic [7:0] tx_byte;
    logic       busy;
    logic       pkt_done;
    logic       underrun;
    logic [2:0] dbg_state;

`ifdef USB_TX_UNDERRUN_EN
    localparam logic UR_EN = 1'b1;
`else
    localparam logic UR_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    usb_tx_pkt_ctrl #(.FIFO_DEPTH(4), .SYNC_BYTE(8'h80)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .fifo_full      (fifo_full),
        .start_pkt      (start_pkt),
        .pid            (pid),
        .byte_sent      (byte_sent),
        .data_sent      (data_sent),
        .transmitting   (transmitting),
        .transmit_empty (transmit_empty),
        .tx_byte        (tx_byte),
        .busy           (busy),
        .pkt_done       (pkt_done),
        .underrun       (underrun),
        .dbg_state      (dbg_state)
    );

    // ------------------------------------------------------ clock / reset
    always #5 clk = ~clk;

    // --------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (tx_byte !== exp_v) begin
                errors++;
                $display("FAIL tx_byte at %0t got %h exp %h", $time, tx_byte, exp_v);
            end
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start(input logic [3:0] p, input logic [7:0] exp_tx);
        start_pkt = 1'b1;
        pid       = p;
        tick();
        start_pkt = 1'b0;
        exp_q.push_back(exp_tx);
    endtask

    task automatic drive_step(input logic bs, input logic ds, input logic [7:0] exp_tx);
        byte_sent = bs;
        data_sent = ds;
        tick();
        byte_sent = 1'b0;
        data_sent = 1'b0;
        exp_q.push_back(exp_tx);
    endtask

    // ---------------------------------------------------------- scenarios
    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({busy, transmitting, transmit_empty, pkt_done, underrun, fifo_full} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_flags got %b exp %b",
                     {busy, transmitting, transmit_empty, pkt_done, underrun, fifo_full}, 6'b001000);
        end
        checks++;
        if (tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_byte got %h exp %h", tx_byte, 8'h00);
        end
        checks++;
        if (dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got %0d exp %0d", dbg_state, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ack();
        start(4'h2, 8'h80);
        checks++;
        if ({busy, transmitting, transmit_empty} !== 3'b111) begin
            errors++;
            $display("FAIL ack_start_flags got %b exp %b", {busy, transmitting, transmit_empty}, 3'b111);
        end
        drive_step(1'b1, 1'b0, 8'hD2);
        drive_step(1'b1, 1'b0, 8'h00);
        checks++;
        if (dbg_state !== 3'd4) begin
            errors++;
            $display("FAIL ack_hold_state got %0d exp %0d", dbg_state, 4);
        end
        drive_step(1'b1, 1'b1, 8'h00);
        checks++;
        if ({pkt_done, transmitting, busy} !== 3'b100) begin
            errors++;
            $display("FAIL ack_end_flags got %b exp %b", {pkt_done, transmitting, busy}, 3'b100);
        end
        tick();
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL ack_pkt_done_width got %b exp %b", pkt_done, 1'b0);
        end
        // Timer pulse while idle must not start anything or move tx_byte.
        drive_step(1'b1, 1'b0, 8'h00);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_byte_sent_busy got %b exp %b", busy, 1'b0);
        end
    endtask

    task automatic test_data_and_underrun();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL data_fifo_full got %b exp %b", fifo_full, 1'b0);
        end
        start(4'h3, 8'h80);
        checks++;
        if (transmit_empty !== 1'b0) begin
            errors++;
            $display("FAIL data_transmit_empty got %b exp %b", transmit_empty, 1'b0);
        end
        drive_step(1'b1, 1'b0, 8'hC3);
        drive_step(1'b1, 1'b0, 8'h11);
        drive_step(1'b1, 1'b0, 8'h22);
        drive_step(1'b1, 1'b0, 8'h33);
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL data_no_underrun got %b exp %b", underrun, 1'b0);
        end
        // FIFO is now empty: filler byte and underrun event.
        drive_step(1'b1, 1'b0, 8'h00);
        checks++;
        if (underrun !== UR_EN) begin
            errors++;
            $display("FAIL underrun_set got %b exp %b", underrun, UR_EN);
        end
        drive_step(1'b0, 1'b1, 8'h00);
        checks++;
        if ({pkt_done, underrun} !== {1'b1, UR_EN}) begin
            errors++;
            $display("FAIL underrun_sticky got %b exp %b", {pkt_done, underrun}, {1'b1, UR_EN});
        end
        start(4'h3, 8'h80);
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear got %b exp %b", underrun, 1'b0);
        end
        drive_step(1'b1, 1'b0, 8'hC3);
        drive_step(1'b0, 1'b1, 8'hC3);
        checks++;
        if ({busy, underrun} !== 2'b00) begin
            errors++;
            $display("FAIL pid_end_flags got %b exp %b", {busy, underrun}, 2'b00);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            push_byte(8'hA0 + 8'(i));
        end
        checks++;
        if (fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_after_fill got %b exp %b", fifo_full, 1'b1);
        end
        push_byte(8'hA4);
        checks++;
        if (fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_after_drop got %b exp %b", fifo_full, 1'b1);
        end
        start(4'h3, 8'h80);
        drive_step(1'b1, 1'b0, 8'hC3);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        drive_step(1'b1, 1'b0, 8'hA0);
        wr_en   = 1'b0;
        checks++;
        if (fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop got %b exp %b", fifo_full, 1'b1);
        end
        drive_step(1'b1, 1'b0, 8'hA1);
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL full_after_pop got %b exp %b", fifo_full, 1'b0);
        end
        drive_step(1'b1, 1'b0, 8'hA2);
        drive_step(1'b1, 1'b0, 8'hA3);
        drive_step(1'b1, 1'b0, 8'hA5);
        drive_step(1'b1, 1'b0, 8'h00);
        drive_step(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_busy_and_reset();
        push_byte(8'hB0);
        push_byte(8'hB1);
        start(4'h3, 8'h80);
        start(4'h2, 8'h80);
        checks++;
        if (transmit_empty !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_ignored got %b exp %b", transmit_empty, 1'b0);
        end
        drive_step(1'b1, 1'b0, 8'hC3);
        drive_step(1'b1, 1'b0, 8'hB0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, transmitting, transmit_empty, pkt_done, underrun, fifo_full} !== 6'b001000) begin
            errors++;
            $display("FAIL midpkt_reset_flags got %b exp %b",
                     {busy, transmitting, transmit_empty, pkt_done, underrun, fifo_full}, 6'b001000);
        end
        checks++;
        if (tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL midpkt_reset_tx got %h exp %h", tx_byte, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if ({pkt_done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL after_reset_flags got %b exp %b", {pkt_done, busy}, 2'b00);
        end
        // B1 must have been flushed by reset.
        push_byte(8'hC0);
        start(4'h3, 8'h80);
        drive_step(1'b1, 1'b0, 8'hC3);
        drive_step(1'b1, 1'b0, 8'hC0);
        drive_step(1'b0, 1'b1, 8'hC0);
    endtask

    task automatic test_back_to_back_collide();
        push_byte(8'hD0);
        push_byte(8'hD1);
        start(4'h3, 8'h80);
        drive_step(1'b1, 1'b0, 8'hC3);
        drive_step(1'b1, 1'b0, 8'hD0);
        drive_step(1'b1, 1'b1, 8'hD0);
        checks++;
        if ({pkt_done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL collide_end got %b exp %b", {pkt_done, busy}, 2'b10);
        end
        start(4'h3, 8'h80);
        drive_step(1'b1, 1'b0, 8'hC3);
        drive_step(1'b1, 1'b0, 8'hD1);
        drive_step(1'b1, 1'b0, 8'h00);
        drive_step(1'b0, 1'b1, 8'h00);
    endtask

    // ------------------------------------------------------------- report
    initial begin
        test_reset();
        test_ack();
        test_data_and_underrun();
        test_full();
        test_busy_and_reset();
        test_back_to_back_collide();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp %0d", exp_q.size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
